health_meter: RTL and testbench

Parametrised player health meter for the HUD: tracks hit points under damage and heal events, enforces a frame-counted invulnerability window after each hit, and declares game over at zero. Renders a two-colour fill bar at a fixed screen position from the shared `hcount_in`/`vcount_in` raster and exports BCD hit-point digits for the font renderers. Sits beside the other HUD sprites, feeding the top-level pixel mux and game-state logic.

---
 rtl/hud_pkg.sv | 24 ++
 rtl/health_meter_hp_to_bcd.sv | 49 ++++
 rtl/health_meter.sv | 206 ++++++++++++++++++++
 tb/tb_health_meter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hud_pkg.sv
// hud_pkg: types and constants shared by the HUD sprite blocks.
//   hm_state_t : health meter life-cycle states
//   rgb12_t    : 12-bit RGB pixel (4 bits per channel)
//   bcd2()     : 0..99 integer to packed two-digit BCD {tens, ones}
package hud_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } hm_state_t;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t COLOR_BLACK  = 12'h000;
  localparam rgb12_t COLOR_YELLOW = 12'hFF0;
  localparam rgb12_t COLOR_ORANGE = 12'hF80;
  localparam rgb12_t COLOR_RED    = 12'hF00;

  function automatic logic [7:0] bcd2(input int v);
    bcd2 = {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/health_meter_hp_to_bcd.sv
// hp_to_bcd: sequential 7-bit (0..99) to two-digit BCD converter.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (control only)
//   start          : load value and begin; also restarts a running conversion
//   value[6:0]     : binary input, sampled on start
//   busy           : conversion in progress
//   done           : high in the cycle the result on tens/ones is final
//   tens/ones[3:0] : result digits, valid while done is high
// Converts by subtracting 10 per cycle, so latency is value/10 + 1 cycles.
module hp_to_bcd (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] value,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] rem_p0;
  logic [3:0] acc_p0;

  assign done = busy && (rem_p0 < 7'd10);
  assign tens = acc_p0;
  assign ones = rem_p0[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
    end else if (done) begin
      busy <= 1'b0;
    end
  end

  // subtract-ten stage: remainder and tens count
  always_ff @(posedge clk) begin
    if (start) begin
      rem_p0 <= value;
      acc_p0 <= 4'd0;
    end else if (busy && !done) begin
      rem_p0 <= rem_p0 - 7'd10;
      acc_p0 <= acc_p0 + 4'd1;
    end
  end

endmodule

// File: rtl/health_meter.sv
// health_meter: player hit-point tracker and HUD fill bar.
// Ports:
//   clk, rst                 : pixel clock, synchronous active-high reset
//   hcount_in, vcount_in     : shared raster position
//   damage_in, heal_in       : level inputs; each rising edge is one event
//   hp_out                   : current hit points
//   hp_tens_out, hp_ones_out : BCD digits of hp_out (lag hp_out by <= 11 cycles)
//   hit_out                  : one-cycle pulse per applied damage
//   invuln_out               : damage immunity window active
//   game_over_out            : sticky until rst once hp reaches 0
//   pixel_out, in_sprite_out : bar colour and bar-rectangle flag (combinational)
// Build option: define HEALTH_FLASH_EN to blink the filled part of the bar
// while invulnerable (bit 2 of the frame counter, i.e. every 4 frames).
module health_meter
  import hud_pkg::*;
#(
  parameter int     MAX_HP        = 56,
  parameter int     DAMAGE        = 8,
  parameter int     HEAL          = 8,
  parameter int     LOW_HP        = 16,
  parameter int     INVULN_FRAMES = 30,
  parameter int     PX_PER_HP     = 2,
  parameter int     POS_X         = 480,
  parameter int     POS_Y         = 720,
  parameter int     HEIGHT        = 32,
  parameter rgb12_t FILL_COLOR    = 12'hFF0,
  parameter rgb12_t LOW_COLOR     = 12'hF80,
  parameter rgb12_t EMPTY_COLOR   = 12'hF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        damage_in,
  input  logic        heal_in,
  output logic [6:0]  hp_out,
  output logic [3:0]  hp_tens_out,
  output logic [3:0]  hp_ones_out,
  output logic        hit_out,
  output logic        invuln_out,
  output logic        game_over_out,
  output rgb12_t      pixel_out,
  output logic        in_sprite_out
);

  // 8-bit hit-point arithmetic leaves headroom for hp + HEAL before clamping
  localparam logic [7:0]  MAX8     = 8'(MAX_HP);
  localparam logic [7:0]  DMG8     = 8'(DAMAGE);
  localparam logic [7:0]  HEAL8    = 8'(HEAL);
  localparam logic [7:0]  LOW8     = 8'(LOW_HP);
  localparam logic [7:0]  CNT_LOAD = 8'(INVULN_FRAMES);
  localparam logic [10:0] BAR_X0   = 11'(POS_X);
  localparam logic [10:0] BAR_X1   = 11'(POS_X + MAX_HP * PX_PER_HP);
  localparam logic [9:0]  BAR_Y0   = 10'(POS_Y);
  localparam logic [9:0]  BAR_Y1   = 10'(POS_Y + HEIGHT);
  localparam logic [7:0]  INIT_BCD = bcd2(MAX_HP);

  function automatic logic [7:0] sub_sat(input logic [7:0] v);
    sub_sat = (v > DMG8) ? (v - DMG8) : 8'd0;
  endfunction

  function automatic logic [7:0] add_sat(input logic [7:0] v);
    logic [7:0] sum;
    sum = v + HEAL8;
    add_sat = (sum > MAX8) ? MAX8 : sum;
  endfunction

  function automatic logic [10:0] fill_edge(input logic [7:0] v);
    fill_edge = BAR_X0 + 11'(v) * 11'(PX_PER_HP);
  endfunction

  logic        damage_prev, heal_prev;
  logic        damage_edge, heal_edge, frame_tick;
  hm_state_t   state, state_n;
  logic [7:0]  hp, hp_n;
  logic [7:0]  cnt, cnt_n;
  logic        hit_n;
  logic [10:0] fill_x;
  logic [3:0]  tens_q, ones_q;
  logic        cvt_start, cvt_busy, cvt_done;
  logic [3:0]  cvt_tens, cvt_ones;
  logic        flash;
  logic        in_bar;

  // Previous-level registers run through reset so a level held across
  // reset release is not mistaken for an event.
  always_ff @(posedge clk) begin
    damage_prev <= damage_in;
    heal_prev   <= heal_in;
  end

  assign damage_edge = damage_in && !damage_prev;
  assign heal_edge   = heal_in && !heal_prev;
  assign frame_tick  = (hcount_in == 11'd0) && (vcount_in == 10'd0);

  always_comb begin
    state_n = state;
    hp_n    = hp;
    cnt_n   = cnt;
    hit_n   = 1'b0;
    case (state)
      ALIVE: begin
        // damage wins over a coincident heal
        if (damage_edge) begin
          hp_n  = sub_sat(hp);
          hit_n = 1'b1;
          if (hp_n == 8'd0) begin
            state_n = DEAD;
          end else if (INVULN_FRAMES > 0) begin
            state_n = INVULN;
            cnt_n   = CNT_LOAD;
          end
        end else if (heal_edge) begin
          hp_n = add_sat(hp);
        end
      end
      INVULN: begin
        if (heal_edge) begin
          hp_n = add_sat(hp);
        end
        if (frame_tick) begin
          if (cnt <= 8'd1) begin
            cnt_n   = 8'd0;
            state_n = ALIVE;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
      end
      DEAD:    state_n = DEAD;
      default: state_n = ALIVE;
    endcase
  end

  // state / hp / fill-edge register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ALIVE;
      hp     <= MAX8;
      cnt    <= 8'd0;
      hit_out <= 1'b0;
      fill_x <= fill_edge(MAX8);
    end else begin
      state  <= state_n;
      hp     <= hp_n;
      cnt    <= cnt_n;
      hit_out <= hit_n;
      fill_x <= fill_edge(hp_n);
    end
  end

  assign hp_out        = hp[6:0];
  assign invuln_out    = (state == INVULN);
  assign game_over_out = (state == DEAD);

  // The converter loads the new hp on the same edge hp_out changes.
  assign cvt_start = (hp_n != hp);

  hp_to_bcd u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (cvt_start),
    .value (hp_n[6:0]),
    .busy  (cvt_busy),
    .done  (cvt_done),
    .tens  (cvt_tens),
    .ones  (cvt_ones)
  );

  // digit output stage: a result is dropped if a restart lands on it
  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q <= INIT_BCD[7:4];
      ones_q <= INIT_BCD[3:0];
    end else if (cvt_busy && cvt_done && !cvt_start) begin
      tens_q <= cvt_tens;
      ones_q <= cvt_ones;
    end
  end

  assign hp_tens_out = tens_q;
  assign hp_ones_out = ones_q;

`ifdef HEALTH_FLASH_EN
  assign flash = (state == INVULN) && cnt[2];
`else
  assign flash = 1'b0;
`endif

  assign in_bar = (hcount_in >= BAR_X0) && (hcount_in < BAR_X1) &&
                  (vcount_in >= BAR_Y0) && (vcount_in < BAR_Y1);

  always_comb begin
    pixel_out = COLOR_BLACK;
    if (in_bar) begin
      if ((hcount_in < fill_x) && !flash) begin
        pixel_out = (hp <= LOW8) ? LOW_COLOR : FILL_COLOR;
      end else begin
        pixel_out = EMPTY_COLOR;
      end
    end
  end

  assign in_sprite_out = in_bar;

endmodule

// File: tb/tb_health_meter.sv
// Directed bench for health_meter: one default instance (56 HP, 30-frame
// invulnerability) and one with MAX_HP=20, INVULN_FRAMES=0 for the death path.
module tb_health_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        damage, heal, damage2, heal2;

  logic [6:0]  hp, hp2;
  logic [3:0]  tens, ones, tens2, ones2;
  logic        hit, hit2, invuln, invuln2, go, go2;
  logic [11:0] pixel, pixel2;
  logic        insp, insp2;

  int tests = 0;
  int fails = 0;

`ifdef HEALTH_FLASH_EN
  localparam logic [11:0] FILL_INVULN30 = 12'hF00;
`else
  localparam logic [11:0] FILL_INVULN30 = 12'hFF0;
`endif

  health_meter dut (
    .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
    .damage_in(damage), .heal_in(heal), .hp_out(hp),
    .hp_tens_out(tens), .hp_ones_out(ones), .hit_out(hit),
    .invuln_out(invuln), .game_over_out(go), .pixel_out(pixel),
    .in_sprite_out(insp)
  );

  health_meter #(.MAX_HP(20), .INVULN_FRAMES(0)) dut2 (
    .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
    .damage_in(damage2), .heal_in(heal2), .hp_out(hp2),
    .hp_tens_out(tens2), .hp_ones_out(ones2), .hit_out(hit2),
    .invuln_out(invuln2), .game_over_out(go2), .pixel_out(pixel2),
    .in_sprite_out(insp2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic [10:0] x, input logic [9:0] y);
    hcount = x;
    vcount = y;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      hcount = 11'd0;
      vcount = 10'd0;
      step();
      hcount = 11'd100;
      vcount = 10'd100;
      step();
    end
  endtask

  initial begin
    rst = 1'b1; damage = 0; heal = 0; damage2 = 0; heal2 = 0;
    hcount = 11'd100; vcount = 10'd100;
    repeat (3) step();
    rst = 1'b0;
    step();

    // reset state
    check("rst_hp", hp, 56);
    check("rst_tens", tens, 5);
    check("rst_ones", ones, 6);
    check("rst_hit", hit, 0);
    check("rst_invuln", invuln, 0);
    check("rst_go", go, 0);
    check("rst_hp2", hp2, 20);
    check("rst_digits2", {tens2, ones2}, 8'h20);
    pix(11'd480, 10'd720);
    check("pix_480_720", pixel, 12'hFF0);
    check("spr_480_720", insp, 1);
    pix(11'd591, 10'd751);
    check("pix_591_751", pixel, 12'hFF0);
    pix(11'd592, 10'd720);
    check("pix_592_720", pixel, 12'h000);
    check("spr_592_720", insp, 0);
    pix(11'd480, 10'd752);
    check("pix_480_752", pixel, 12'h000);
    pix(11'd479, 10'd720);
    check("pix_479_720", pixel, 12'h000);
    pix(11'd100, 10'd100);

    // first hit
    damage = 1'b1;
    step();
    check("hit1_hp", hp, 48);
    check("hit1_pulse", hit, 1);
    check("hit1_invuln", invuln, 1);
    pix(11'd480, 10'd720);
    check("hit1_flash_pix", pixel, FILL_INVULN30);
    pix(11'd100, 10'd100);
    step();
    check("hit1_pulse_end", hit, 0);
    damage = 1'b0;
    repeat (10) step();
    check("hit1_tens", tens, 4);
    check("hit1_ones", ones, 8);
    pix(11'd576, 10'd720);
    check("pix_576_720", pixel, 12'hF00);
    pix(11'd575, 10'd720);
    check("pix_575_720", pixel, FILL_INVULN30);
    pix(11'd100, 10'd100);

    // damage while invulnerable is ignored
    damage = 1'b1;
    step();
    check("inv_hp", hp, 48);
    check("inv_hit", hit, 0);
    damage = 1'b0;
    step();
    ticks(29);
    check("inv_29", invuln, 1);
    ticks(1);
    check("inv_30", invuln, 0);

    // second applied hit
    damage = 1'b1;
    step();
    check("hit2_hp", hp, 40);
    check("hit2_pulse", hit, 1);
    damage = 1'b0;
    step();

    // heal during invulnerability
    heal = 1'b1;
    step();
    check("heal_inv_hp", hp, 48);
    check("heal_inv_state", invuln, 1);
    heal = 1'b0;
    step();
    ticks(3);
    pix(11'd480, 10'd720);
    check("flash_off_pix", pixel, 12'hFF0);
    pix(11'd100, 10'd100);
    ticks(27);
    check("inv2_end", invuln, 0);

    // heal to max and clamp
    heal = 1'b1;
    step();
    check("heal_max", hp, 56);
    heal = 1'b0;
    step();
    heal = 1'b1;
    step();
    check("heal_clamp", hp, 56);
    heal = 1'b0;
    step();

    // simultaneous events in ALIVE: damage wins
    damage = 1'b1; heal = 1'b1;
    step();
    check("both_alive_hp", hp, 48);
    check("both_alive_hit", hit, 1);
    damage = 1'b0; heal = 1'b0;
    step();
    // simultaneous events in INVULN: heal applies
    damage = 1'b1; heal = 1'b1;
    step();
    check("both_inv_hp", hp, 56);
    check("both_inv_hit", hit, 0);
    damage = 1'b0; heal = 1'b0;
    step();

    // reset mid-invulnerability / mid-conversion
    rst = 1'b1;
    step();
    check("rst_mid_invuln", invuln, 0);
    check("rst_mid_hp", hp, 56);
    rst = 1'b0;
    step();
    check("rst_mid_digits", {tens, ones}, 8'h56);

    // no-invulnerability instance down to death
    damage2 = 1'b1;
    step();
    check("d2_hp12", hp2, 12);
    check("d2_hit12", hit2, 1);
    check("d2_inv12", invuln2, 0);
    damage2 = 1'b0;
    step();
    pix(11'd480, 10'd720);
    check("d2_low_pix", pixel2, 12'hF80);
    pix(11'd503, 10'd720);
    check("d2_low_edge", pixel2, 12'hF80);
    pix(11'd504, 10'd720);
    check("d2_empty_edge", pixel2, 12'hF00);
    pix(11'd520, 10'd720);
    check("d2_outside", pixel2, 12'h000);
    pix(11'd100, 10'd100);
    damage2 = 1'b1;
    step();
    check("d2_hp4", hp2, 4);
    damage2 = 1'b0;
    step();
    damage2 = 1'b1;
    step();
    check("d2_hp0", hp2, 0);
    check("d2_go", go2, 1);
    check("d2_hit0", hit2, 1);
    damage2 = 1'b0;
    step();
    pix(11'd480, 10'd720);
    check("d2_dead_pix", pixel2, 12'hF00);
    pix(11'd100, 10'd100);
    heal2 = 1'b1;
    step();
    check("d2_heal_dead", hp2, 0);
    heal2 = 1'b0;
    repeat (12) step();
    check("d2_go_sticky", go2, 1);
    check("d2_digits0", {tens2, ones2}, 8'h00);
    check("d1_untouched", hp, 56);

    // damage held through reset release is not an event
    damage = 1'b1;
    rst = 1'b1;
    repeat (2) step();
    check("d2_rst_hp", hp2, 20);
    check("d2_rst_go", go2, 0);
    rst = 1'b0;
    step();
    check("held_hp", hp, 56);
    check("held_hit", hit, 0);
    step();
    check("held_hp_late", hp, 56);
    check("held_invuln", invuln, 0);
    damage = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
